// File: rtl/abacus_sample_controller.sv
// abacus_sample_controller: windows the profiler enable for a programmed
// interval, then freezes the counters and packs a header plus the selected
// counter values into a first-word-fall-through sample FIFO.
module abacus_sample_controller #(
  parameter int NUM_COUNTERS = 8,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_start,
  input  logic                              cfg_stop,
  input  logic [31:0]                       cfg_interval,
  input  logic [NUM_COUNTERS-1:0]           cfg_mask,
  input  logic                              cfg_clr_ovf,
  output logic                              profiler_enable,
  output logic [$clog2(NUM_COUNTERS)-1:0]   cnt_rd_sel,
  input  logic [31:0]                       cnt_rd_data,
  input  logic                              fifo_rd,
  output logic [31:0]                       fifo_dout,
  output logic                              fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              ovf,
  output logic [15:0]                       drop_count,
  output logic                              busy
);

  localparam int SEL_W = $clog2(NUM_COUNTERS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, RUN, SETTLE, HEADER, CAPTURE} state_t;

  state_t                  state_reg, state_next;
  logic [31:0]             timer_reg, timer_next;
  logic [31:0]             interval_reg, interval_next;
  logic [NUM_COUNTERS-1:0] mask_reg, mask_next;
  logic [SEL_W-1:0]        idx_reg, idx_next;
  logic [15:0]             seq_reg, seq_next;
  logic                    stop_pending_reg, stop_pending_next;
  logic                    enable_reg;
  logic                    ovf_reg;
  logic [15:0]             drop_reg;

  logic                    push;
  logic [31:0]             push_data;
  logic                    drop;
  logic                    stop_eff;
  logic [31:0]             load_interval;
  logic [LVL_W-1:0]        need;
  logic [LVL_W-1:0]        free_words;

  // FIFO storage and pointers
  logic [31:0]             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [LVL_W-1:0]        level_reg;
  logic [31:0]             dout_reg;
  logic                    pop;

  assign stop_eff      = stop_pending_reg | cfg_stop;
  assign load_interval = (cfg_interval == 32'd0) ? 32'd1 : cfg_interval;
  assign free_words    = LVL_W'(FIFO_DEPTH) - level_reg;
  assign pop           = fifo_rd && (level_reg != '0);
  assign rd_ptr_inc    = rd_ptr_reg + PTR_W'(1);

  // Words one frame needs: header plus one per masked counter.
  always_comb begin
    need = LVL_W'(1);
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      need = need + LVL_W'(mask_reg[i]);
    end
  end

  // Next-state logic plus the FIFO push request for the sampling FSM.
  always_comb begin
    state_next        = state_reg;
    timer_next        = timer_reg;
    interval_next     = interval_reg;
    mask_next         = mask_reg;
    idx_next          = '0;
    seq_next          = seq_reg;
    stop_pending_next = stop_pending_reg;
    push              = 1'b0;
    push_data         = cnt_rd_data;
    drop              = 1'b0;
    case (state_reg)
      IDLE: begin
        stop_pending_next = 1'b0;
        if (cfg_start) begin
          interval_next = load_interval;
          mask_next     = cfg_mask;
          timer_next    = load_interval;
          state_next    = RUN;
        end
      end
      RUN: begin
        timer_next = timer_reg - 32'd1;
        if (cfg_stop) begin
          state_next = IDLE;
        end else if (timer_reg == 32'd1) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (free_words < need) begin
          drop              = 1'b1;
          timer_next        = interval_reg;
          state_next        = stop_eff ? IDLE : RUN;
          stop_pending_next = 1'b0;
        end else begin
          state_next        = HEADER;
          stop_pending_next = stop_eff;
        end
      end
      HEADER: begin
        push              = 1'b1;
        push_data         = {16'hABAC, seq_reg};
        state_next        = CAPTURE;
        stop_pending_next = stop_eff;
      end
      CAPTURE: begin
        push = mask_reg[idx_reg];
        if (idx_reg == SEL_W'(NUM_COUNTERS - 1)) begin
          seq_next          = seq_reg + 16'd1;
          timer_next        = interval_reg;
          state_next        = stop_eff ? IDLE : RUN;
          stop_pending_next = 1'b0;
        end else begin
          idx_next          = idx_reg + SEL_W'(1);
          stop_pending_next = stop_eff;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM registers; the enable is registered from the next state so it
  // tracks RUN exactly without a combinational output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      timer_reg        <= 32'd0;
      interval_reg     <= 32'd1;
      mask_reg         <= '0;
      idx_reg          <= '0;
      seq_reg          <= 16'd0;
      stop_pending_reg <= 1'b0;
      enable_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      timer_reg        <= timer_next;
      interval_reg     <= interval_next;
      mask_reg         <= mask_next;
      idx_reg          <= idx_next;
      seq_reg          <= seq_next;
      stop_pending_reg <= stop_pending_next;
      enable_reg       <= (state_next == RUN);
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg  <= 1'b0;
      drop_reg <= 16'd0;
    end else if (drop) begin
      ovf_reg  <= 1'b1;
      if (cfg_clr_ovf) begin
        drop_reg <= 16'd1;
      end else if (drop_reg != 16'hFFFF) begin
        drop_reg <= drop_reg + 16'd1;
      end
    end else if (cfg_clr_ovf) begin
      ovf_reg  <= 1'b0;
      drop_reg <= 16'd0;
    end
  end

  // Sample RAM write port; no reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // FIFO pointers, level and the registered head word (look-ahead read).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      dout_reg   <= 32'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
      if (pop) begin
        if (level_reg == LVL_W'(1)) begin
          dout_reg <= push ? push_data : 32'd0;
        end else begin
          dout_reg <= mem[rd_ptr_inc];
        end
      end else if (push && (level_reg == '0)) begin
        dout_reg <= push_data;
      end
    end
  end

  assign profiler_enable = enable_reg;
  assign cnt_rd_sel      = idx_reg;
  assign fifo_dout       = dout_reg;
  assign fifo_empty      = (level_reg == '0);
  assign fifo_level      = level_reg;
  assign ovf             = ovf_reg;
  assign drop_count      = drop_reg;
  assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_abacus_sample_controller.sv
// Directed bench for abacus_sample_controller: expected FIFO words go into a
// queue as frames are launched and are compared as the FIFO is drained.
module tb_abacus_sample_controller;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic        cfg_stop;
  logic [31:0] cfg_interval;
  logic [7:0]  cfg_mask;
  logic        cfg_clr_ovf;
  logic        profiler_enable;
  logic [2:0]  cnt_rd_sel;
  logic [31:0] cnt_rd_data;
  logic        fifo_rd;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic [5:0]  fifo_level;
  logic        ovf;
  logic [15:0] drop_count;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int n;
  logic [31:0] q [$];

  abacus_sample_controller #(.NUM_COUNTERS(8), .FIFO_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_interval(cfg_interval), .cfg_mask(cfg_mask), .cfg_clr_ovf(cfg_clr_ovf),
    .profiler_enable(profiler_enable), .cnt_rd_sel(cnt_rd_sel),
    .cnt_rd_data(cnt_rd_data), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level), .ovf(ovf),
    .drop_count(drop_count), .busy(busy)
  );

  // Counter bank model: counter i reads as 0x100+i.
  assign cnt_rd_data = 32'h100 + 32'(cnt_rd_sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] s, input logic [7:0] m);
    q.push_back({16'hABAC, s});
    for (int i = 0; i < 8; i++) begin
      if (m[i]) q.push_back(32'h100 + 32'(i));
    end
  endtask

  task automatic start(input logic [31:0] iv, input logic [7:0] m);
    cfg_interval = iv;
    cfg_mask     = m;
    cfg_start    = 1'b1;
    tick();
    cfg_start    = 1'b0;
  endtask

  task automatic pulse_stop();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
  endtask

  task automatic measure(input logic val, output int cnt);
    cnt = 0;
    while (profiler_enable === val && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    check(tag, 32'(k < 300), 32'd1);
  endtask

  task automatic wait_sel(input logic [2:0] v, input string tag);
    int k = 0;
    while (!(busy === 1'b1 && cnt_rd_sel === v) && k < 300) begin
      tick();
      k++;
    end
    check(tag, 32'(k < 300), 32'd1);
  endtask

  task automatic wait_level(input logic [5:0] v, input string tag);
    int k = 0;
    while (fifo_level !== v && k < 300) begin
      tick();
      k++;
    end
    check(tag, 32'(k < 300), 32'd1);
  endtask

  // Pops every available word, comparing each with the scoreboard head.
  task automatic drain(input string tag);
    int k = 0;
    logic [31:0] exp;
    while ((q.size() > 0 || fifo_empty !== 1'b1) && k < 2000) begin
      if (fifo_empty === 1'b0) begin
        exp = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
        check(tag, fifo_dout, exp);
        fifo_rd = 1'b1;
      end else begin
        fifo_rd = 1'b0;
      end
      tick();
      k++;
    end
    fifo_rd = 1'b0;
    check({tag, "_bound"}, 32'(k < 2000), 32'd1);
    check({tag, "_empty"}, 32'(fifo_level), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_interval = 32'd0;
    cfg_mask = 8'd0; cfg_clr_ovf = 1'b0; fifo_rd = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_en", 32'(profiler_enable), 32'd0);
    check("rst_sel", 32'(cnt_rd_sel), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_dout", fifo_dout, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Basic frame: 10 high, 10 low, 10 high; stop in SETTLE completes frame 2.
    push_frame(16'd0, 8'h05);
    push_frame(16'd1, 8'h05);
    start(32'd10, 8'h05);
    measure(1'b1, n); check("t1_high1", 32'(n), 32'd10);
    measure(1'b0, n); check("t1_low", 32'(n), 32'd10);
    check("t1_level3", 32'(fifo_level), 32'd3);
    measure(1'b1, n); check("t1_high2", 32'(n), 32'd10);
    pulse_stop();
    wait_idle("t1_idle");
    check("t1_en_off", 32'(profiler_enable), 32'd0);
    check("t1_level6", 32'(fifo_level), 32'd6);
    drain("t1_word");

    // Three full frames while draining continuously.
    do_reset();
    push_frame(16'd0, 8'hFF);
    push_frame(16'd1, 8'hFF);
    push_frame(16'd2, 8'hFF);
    start(32'd5, 8'hFF);
    drain("t2_word");
    pulse_stop();
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_ovf", 32'(ovf), 32'd0);

    // Overflow: no draining, fourth frame dropped.
    do_reset();
    push_frame(16'd0, 8'hFF);
    push_frame(16'd1, 8'hFF);
    push_frame(16'd2, 8'hFF);
    start(32'd3, 8'hFF);
    n = 0;
    while (ovf !== 1'b1 && n < 300) begin tick(); n++; end
    check("t3_ovf_seen", 32'(n < 300), 32'd1);
    check("t3_level27", 32'(fifo_level), 32'd27);
    check("t3_drop1", 32'(drop_count), 32'd1);
    measure(1'b1, n); check("t3_high", 32'(n), 32'd3);
    measure(1'b0, n); check("t3_gap", 32'(n), 32'd1);
    check("t3_drop2", 32'(drop_count), 32'd2);
    cfg_clr_ovf = 1'b1;
    tick();
    cfg_clr_ovf = 1'b0;
    check("t3_clr_ovf", 32'(ovf), 32'd0);
    check("t3_clr_drop", 32'(drop_count), 32'd0);
    pulse_stop();
    wait_idle("t3_idle");
    drain("t3_word");

    // Stop during CAPTURE idx 3: the frame still completes.
    do_reset();
    push_frame(16'd0, 8'hFF);
    start(32'd4, 8'hFF);
    wait_sel(3'd3, "t4_sel3");
    pulse_stop();
    wait_idle("t4_idle");
    check("t4_en", 32'(profiler_enable), 32'd0);
    check("t4_level9", 32'(fifo_level), 32'd9);
    drain("t4_word");

    // Stop in RUN: IDLE on the next cycle, no words.
    start(32'd20, 8'hFF);
    check("t5_en_run", 32'(profiler_enable), 32'd1);
    tick();
    pulse_stop();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_en", 32'(profiler_enable), 32'd0);
    tick(); tick(); tick();
    check("t5_level", 32'(fifo_level), 32'd0);

    // Interval 0 behaves as 1.
    push_frame(16'd1, 8'h01);
    start(32'd0, 8'h01);
    measure(1'b1, n); check("t6_high", 32'(n), 32'd1);
    pulse_stop();
    wait_idle("t6_idle");
    drain("t6_word");

    // cfg_start while busy is ignored.
    push_frame(16'd2, 8'h03);
    start(32'd6, 8'h03);
    cfg_mask = 8'hFF; cfg_interval = 32'd20; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    measure(1'b1, n); check("t7_high", 32'(n), 32'd5);
    pulse_stop();
    wait_idle("t7_idle");
    drain("t7_word");

    // Simultaneous push and pop at level 5.
    do_reset();
    push_frame(16'd0, 8'hFF);
    start(32'd3, 8'hFF);
    wait_level(6'd5, "t8_lvl5");
    check("t8_head", fifo_dout, q.pop_front());
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    check("t8_level_hold", 32'(fifo_level), 32'd5);
    pulse_stop();
    wait_idle("t8_idle");
    check("t8_level8", 32'(fifo_level), 32'd8);
    drain("t8_word");

    // Asynchronous reset in the middle of CAPTURE.
    start(32'd3, 8'hFF);
    wait_sel(3'd2, "t9_sel2");
    rst = 1'b1;
    #1;
    check("t9_en", 32'(profiler_enable), 32'd0);
    check("t9_sel", 32'(cnt_rd_sel), 32'd0);
    check("t9_empty", 32'(fifo_empty), 32'd1);
    check("t9_level", 32'(fifo_level), 32'd0);
    check("t9_dout", fifo_dout, 32'd0);
    check("t9_busy", 32'(busy), 32'd0);
    check("t9_ovf", 32'(ovf), 32'd0);
    check("t9_drop", 32'(drop_count), 32'd0);
    tick();
    rst = 1'b0;
    q.delete();
    tick();
    push_frame(16'd0, 8'h80);
    start(32'd3, 8'h80);
    wait_level(6'd2, "t9_lvl2");
    pulse_stop();
    wait_idle("t9_idle");
    drain("t9_word");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/abacus_sample_controller.md
# abacus_sample_controller

Periodic sampling scheduler for the ABACUS profiling units. It gates the profiler enable for a programmed interval and then freezes the counters. While they are frozen, it walks the counter read-select across the masked counters and packs a header plus the counter values into an internal first-word-fall-through (FWFT) FIFO, then re-enables profiling. It sits between the Wishbone register block, which drives the cfg_* signals and drains the FIFO, and the instruction/cache profiler counter banks.

## Interface
Parameters:
- NUM_COUNTERS, 8: counters reachable through the read-select mux (2..16).
- FIFO_DEPTH, 32: sample FIFO entries, power of two, at least NUM_COUNTERS+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- cfg_start  in  1  pulse; starts sampling from IDLE.
- cfg_stop  in  1  pulse; ends sampling at the next frame boundary.
- cfg_interval  in  32  enabled cycles per sample window; latched at start.
- cfg_mask  in  NUM_COUNTERS  counters captured per frame; latched at start.
- cfg_clr_ovf  in  1  pulse; clears ovf and drop_count.
- profiler_enable  out  1  registered enable to the profiler units.
- cnt_rd_sel  out  $clog2(NUM_COUNTERS)  counter index selected.
- cnt_rd_data  in  32  selected counter value, combinational from cnt_rd_sel.
- fifo_rd  in  1  pop strobe.
- fifo_dout  out  32  FIFO head word, FWFT.
- fifo_empty  out  1  FIFO holds no words.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words held.
- ovf  out  1  sticky; set when a frame was dropped.
- drop_count  out  16  frames dropped, saturating.
- busy  out  1  FSM is not in IDLE.

## Operation
- States: IDLE, RUN, SETTLE, HEADER, CAPTURE.
- IDLE:
  - profiler_enable=0.
  - On cfg_start: latch interval and mask, load timer, go to RUN. A latched interval of 0 is treated as 1.
- RUN:
  - profiler_enable=1.
  - timer decrements each cycle. When timer==1, go to SETTLE.
  - On cfg_stop: go to IDLE immediately; no frame is produced.
- SETTLE:
  - profiler_enable=0. This is a one-cycle wait so the counters absorb their last increment.
  - Compute need = popcount(mask)+1.
  - If free entries (FIFO_DEPTH-fifo_level) < need: set ovf, increment drop_count (saturating at 16'hFFFF), reload the timer, go to RUN. If stop is pending, go to IDLE instead.
  - Otherwise go to HEADER.
- HEADER:
  - Push {16'hABAC, seq[15:0]}; seq starts at 0 after reset.
  - Set idx=0 and go to CAPTURE.
- CAPTURE:
  - cnt_rd_sel=idx. Push cnt_rd_data only if mask[idx]==1.
  - idx increments every cycle; unmasked slots still consume a cycle.
  - After idx==NUM_COUNTERS-1: seq++, reload the timer, go to RUN. If stop is pending, go to IDLE instead.
- cfg_stop arriving in SETTLE, HEADER or CAPTURE sets stop_pending. The frame always completes, so frames are atomic.
- cfg_start outside IDLE is ignored. The mask and interval cannot change mid-run.
- FIFO:
  - A simultaneous push and pop is legal; the level is unchanged.
  - fifo_rd when empty is ignored.
  - A push never occurs when full, because the space check in SETTLE guarantees room.
- cfg_clr_ovf clears ovf and drop_count. If it coincides with a drop, the drop wins (ovf=1, drop_count=1).
- cnt_rd_sel is 0 outside CAPTURE.

## Timing
- Reset values: profiler_enable=0, cnt_rd_sel=0, fifo_empty=1, fifo_level=0, fifo_dout=0, ovf=0, drop_count=0, busy=0, seq=0, stop_pending=0.
- Reset mid-frame aborts the frame and empties the FIFO.
- profiler_enable rises on the first clock after cfg_start is sampled. It stays high for exactly the latched interval cycles per window.
- Enable-low gap per captured frame: SETTLE(1) + HEADER(1) + CAPTURE(NUM_COUNTERS) cycles.
- Enable-low gap per dropped frame: 1 cycle.
- A pushed word is visible on fifo_dout the cycle after the push.
- fifo_level updates the cycle after a push or pop.
- cnt_rd_data is sampled in the same cycle cnt_rd_sel is presented. The timing path is cnt_rd_sel flop → mux → FIFO RAM.

## Test plan
- Basic frame:
  - Stimulus: interval=10, mask=8'b0000_0101, counter i returns 32'h100+i; cfg_start.
  - Required: enable high 10 cycles. FIFO then holds ABAC0000, 00000100, 00000102. Enable low 10 cycles, then re-high for 10 cycles.
- Sequence and drain:
  - Stimulus: three frames with mask=8'hFF while draining continuously.
  - Required: headers ABAC0000/ABAC0001/ABAC0002, 9 words per frame, ovf=0.
- Overflow:
  - Stimulus: FIFO_DEPTH=32, mask=8'hFF, no draining.
  - Required: frames 1–3 stored (27 words); frame 4 dropped (needs 9, 5 free). ovf=1, drop_count increments per window. cfg_clr_ovf clears both.
- Stop timing:
  - Stimulus: cfg_stop during CAPTURE idx=3.
  - Required: frame completes with 9 words, then IDLE, enable=0, busy=0.
  - Stimulus: cfg_stop in RUN.
  - Required: IDLE the next cycle with no new words.
- Edge cases:
  - Stimulus: interval=0.
  - Required: behaves as interval=1.
  - Stimulus: cfg_start while busy.
  - Required: ignored; mask unchanged.
  - Stimulus: simultaneous push and pop at level 5.
  - Required: level stays 5.
- Reset mid-CAPTURE:
  - Required: all outputs at reset values immediately (asynchronous), FIFO empty, seq=0.
  - After release: cfg_start yields header ABAC0000.
